// File: rtl/lfsr_counter_gen.sv
// rtl/lfsr_counter_gen.sv - up/down counter and Fibonacci LFSR with wrap pulse and wrapping tap window
// Optional all-zero LFSR recovery: define LFSR_COUNTER_GEN_LOCKUP_EN.
module lfsr_counter_gen #(
    parameter int                WIDTH = 32,
    parameter logic [WIDTH-1:0]  TAPS  = WIDTH'(32'h80200003),
    parameter int                WIN   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [1:0]                 mode,
    input  logic                       load,
    input  logic [WIDTH-1:0]           load_value,
    input  logic [$clog2(WIDTH)-1:0]   tap_index,
    output logic [WIDTH-1:0]           out,
    output logic [WIN-1:0]             tap_output,
    output logic                       wrap,
    output logic                       lockup
);

    localparam int IW = $clog2(WIDTH);

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_LFSR = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] seed_q, seed_d;
    logic             wrap_q, wrap_d;
    logic             fb;
    logic [WIDTH-1:0] lfsr_next;

`ifdef LFSR_COUNTER_GEN_LOCKUP_EN
    logic             lockup_q, lockup_d;
    logic             lfsr_stuck;
`endif

    always_comb begin
        fb        = ^(out_q & TAPS);
        lfsr_next = {out_q[WIDTH-2:0], fb};
`ifdef LFSR_COUNTER_GEN_LOCKUP_EN
        // An all-zero state would shift zeros forever; restart from all ones.
        lfsr_stuck = (out_q == '0);
        if (lfsr_stuck) begin
            lfsr_next = '1;
        end
`endif
    end

    always_comb begin
        out_d    = out_q;
        seed_d   = seed_q;
        wrap_d   = 1'b0;
`ifdef LFSR_COUNTER_GEN_LOCKUP_EN
        lockup_d = lockup_q;
`endif
        if (load) begin
            out_d    = load_value;
            seed_d   = load_value;
`ifdef LFSR_COUNTER_GEN_LOCKUP_EN
            lockup_d = 1'b0;
`endif
        end else if (en && (mode != MODE_HOLD)) begin
            case (mode)
                MODE_UP: begin
                    out_d  = out_q + WIDTH'(1);
                    wrap_d = &out_q;
                end
                MODE_DOWN: begin
                    out_d  = out_q - WIDTH'(1);
                    wrap_d = (out_q == '0);
                end
                MODE_LFSR: begin
                    out_d  = lfsr_next;
                    wrap_d = (lfsr_next == seed_q);
`ifdef LFSR_COUNTER_GEN_LOCKUP_EN
                    if (lfsr_stuck) begin
                        lockup_d = 1'b1;
                    end
`endif
                end
                default: begin
                    out_d = out_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q    <= '1;
            seed_q   <= '1;
            wrap_q   <= 1'b0;
`ifdef LFSR_COUNTER_GEN_LOCKUP_EN
            lockup_q <= 1'b0;
`endif
        end else begin
            out_q    <= out_d;
            seed_q   <= seed_d;
            wrap_q   <= wrap_d;
`ifdef LFSR_COUNTER_GEN_LOCKUP_EN
            lockup_q <= lockup_d;
`endif
        end
    end

    // Window position reduced modulo WIDTH so it wraps past the MSB.
    always_comb begin
        logic [31:0] pos;
        tap_output = '0;
        pos        = '0;
        for (int i = 0; i < WIN; i++) begin
            pos           = (32'(tap_index) + 32'(i)) % 32'(WIDTH);
            tap_output[i] = out_q[pos[IW-1:0]];
        end
    end

    assign out  = out_q;
    assign wrap = wrap_q;
`ifdef LFSR_COUNTER_GEN_LOCKUP_EN
    assign lockup = lockup_q;
`else
    assign lockup = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_counter_gen.sv
// tb/tb_lfsr_counter_gen.sv - scoreboard bench for lfsr_counter_gen (default and WIDTH=4 instances)
module tb_lfsr_counter_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, load;
    logic [1:0]  mode;
    logic [31:0] load_value;
    logic [4:0]  tap_index;
    logic [31:0] out;
    logic [3:0]  tap_output;
    logic        wrap, lockup;

    logic        d4_en, d4_load;
    logic [1:0]  d4_mode;
    logic [3:0]  d4_load_value;
    logic [1:0]  d4_tap_index;
    logic [3:0]  out4;
    logic [3:0]  tap4;
    logic        wrap4, lockup4;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] o;
        logic        w;
        logic        l;
    } exp_t;

    exp_t q[$];
    exp_t q4[$];

    logic [31:0] m_out, m_seed;
    logic        m_wrap, m_lock;
    logic [3:0]  m4_out, m4_seed;
    logic        m4_wrap;

    always #5 clk = ~clk;

    lfsr_counter_gen dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load),
        .load_value(load_value), .tap_index(tap_index), .out(out),
        .tap_output(tap_output), .wrap(wrap), .lockup(lockup)
    );

    lfsr_counter_gen #(.WIDTH(4), .TAPS(4'b1001), .WIN(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(d4_en), .mode(d4_mode), .load(d4_load),
        .load_value(d4_load_value), .tap_index(d4_tap_index), .out(out4),
        .tap_output(tap4), .wrap(wrap4), .lockup(lockup4)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_push();
        exp_t e;
        logic fb;
        if (!rst_n) begin
            m_out = '1; m_seed = '1; m_wrap = 1'b0; m_lock = 1'b0;
        end else if (load) begin
            m_out = load_value; m_seed = load_value; m_wrap = 1'b0; m_lock = 1'b0;
        end else if (en && mode != 2'b11) begin
            case (mode)
                2'b00: begin m_wrap = (m_out == 32'hFFFF_FFFF); m_out = m_out + 32'd1; end
                2'b01: begin m_wrap = (m_out == 32'h0); m_out = m_out - 32'd1; end
                default: begin
`ifdef LFSR_COUNTER_GEN_LOCKUP_EN
                    if (m_out == 32'h0) begin
                        m_out = 32'hFFFF_FFFF; m_lock = 1'b1;
                    end else
`endif
                    begin
                        fb    = m_out[31] ^ m_out[21] ^ m_out[1] ^ m_out[0];
                        m_out = {m_out[30:0], fb};
                    end
                    m_wrap = (m_out == m_seed);
                end
            endcase
        end else begin
            m_wrap = 1'b0;
        end
        e.o = m_out; e.w = m_wrap; e.l = m_lock;
        q.push_back(e);
    endtask

    task automatic model4_push();
        exp_t e;
        if (!rst_n) begin
            m4_out = 4'hF; m4_seed = 4'hF; m4_wrap = 1'b0;
        end else if (d4_load) begin
            m4_out = d4_load_value; m4_seed = d4_load_value; m4_wrap = 1'b0;
        end else if (d4_en && d4_mode == 2'b10) begin
            m4_out  = {m4_out[2:0], m4_out[3] ^ m4_out[0]};
            m4_wrap = (m4_out == m4_seed);
        end else begin
            m4_wrap = 1'b0;
        end
        e.o = {28'h0, m4_out}; e.w = m4_wrap; e.l = 1'b0;
        q4.push_back(e);
    endtask

    task automatic cycle();
        exp_t e;
        logic [3:0] et;
        model_push();
        model4_push();
        @(posedge clk);
        #1;
        if (q.size() == 0 || q4.size() == 0) begin
            chk("sb_empty", 64'd1, 64'd0);
        end else begin
            e = q.pop_front();
            chk("out", out, e.o);
            chk("wrap", wrap, e.w);
            chk("lockup", lockup, e.l);
            for (int i = 0; i < 4; i++) et[i] = e.o[(int'(tap_index) + i) % 32];
            chk("tap", tap_output, et);
            e = q4.pop_front();
            chk("out4", out4, e.o[3:0]);
            chk("wrap4", wrap4, e.w);
            chk("lockup4", lockup4, 1'b0);
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; load = 1'b0; mode = 2'b00;
        load_value = '0; tap_index = '0;
        d4_en = 1'b0; d4_load = 1'b0; d4_mode = 2'b10; d4_load_value = '0; d4_tap_index = '0;
        m_out = '0; m_seed = '0; m_wrap = 1'b0; m_lock = 1'b0;
        m4_out = '0; m4_seed = '0; m4_wrap = 1'b0;

        cycle();
        chk("rst_out", out, 32'hFFFF_FFFF);
        chk("rst_wrap", wrap, 1'b0);

        rst_n = 1'b1; mode = 2'b10; en = 1'b1;
        cycle();
        chk("lfsr1", out, 32'hFFFF_FFFE);
        cycle();
        chk("lfsr2", out, 32'hFFFF_FFFD);
        chk("lfsr2_wrap", wrap, 1'b0);

        rst_n = 1'b0; cycle();
        rst_n = 1'b1; mode = 2'b00; en = 1'b1;
        cycle();
        chk("up_wrap_out", out, 32'h0);
        chk("up_wrap", wrap, 1'b1);
        cycle();
        chk("up_next", out, 32'h1);
        chk("up_next_wrap", wrap, 1'b0);

        load = 1'b1; load_value = 32'h0; cycle();
        chk("load_nowrap", wrap, 1'b0);
        load = 1'b0; mode = 2'b01; cycle();
        chk("down_out", out, 32'hFFFF_FFFF);
        chk("down_wrap", wrap, 1'b1);
        en = 1'b0; cycle();
        chk("hold_out", out, 32'hFFFF_FFFF);
        chk("hold_wrap", wrap, 1'b0);

        load = 1'b1; load_value = 32'h4000_0001; tap_index = 5'd30; cycle();
        load = 1'b0;
        chk("tap30", tap_output, 4'b0101);
        tap_index = 5'd0; #1;
        chk("tap0", tap_output, 4'b0001);

        // Reload the seed value: no wrap on a load edge.
        load = 1'b1; cycle();
        chk("reload_wrap", wrap, 1'b0);
        load = 1'b0;

        for (int k = 0; k < 200; k++) begin
            mode       = 2'($urandom_range(0, 3));
            en         = ($urandom_range(0, 3) != 0);
            load       = ($urandom_range(0, 15) == 0);
            load_value = $urandom();
            if ($urandom_range(0, 7) == 0) load_value = {31'h0, load_value[0]};
            tap_index  = 5'($urandom_range(0, 31));
            cycle();
        end

        load = 1'b1; load_value = 32'h0; en = 1'b1; mode = 2'b10; cycle();
        load = 1'b0; cycle();
`ifdef LFSR_COUNTER_GEN_LOCKUP_EN
        chk("lock_out", out, 32'hFFFF_FFFF);
        chk("lock_flag", lockup, 1'b1);
        cycle();
        chk("lock_sticky", lockup, 1'b1);
`else
        chk("zero_out", out, 32'h0);
        chk("zero_flag", lockup, 1'b0);
        cycle();
        chk("zero_stays", out, 32'h0);
`endif
        load = 1'b1; load_value = 32'h1234_5678; cycle();
        chk("load_clr_lock", lockup, 1'b0);

        rst_n = 1'b0; load = 1'b1; en = 1'b1; cycle();
        chk("rst_wins", out, 32'hFFFF_FFFF);
        rst_n = 1'b1; load = 1'b0; en = 1'b0;

        d4_load = 1'b1; d4_load_value = 4'b0001; cycle();
        d4_load = 1'b0; d4_en = 1'b1; d4_mode = 2'b10;
        for (int k = 1; k <= 30; k++) begin
            cycle();
            chk("p4_wrap", wrap4, (k % 15) == 0);
            if ((k % 15) == 0) chk("p4_seed", out4, 4'b0001);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
